// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch initiator for the four-stage pipeline.
//
// Owns the program counter and drives a word-addressed instruction memory
// port. The memory read is combinational and the port never writes. Each
// fetched word and its PC are registered into the IF/ID boundary. The unit
// handles stall, branch redirect and a halt word. It also keeps a
// saturating count of issued instructions.
//
// Parameters:
//   AW        address/PC width
//   DW        instruction width
//   DEPTH     memory depth in words; the PC wraps modulo DEPTH
//   RESET_PC  PC value after reset
//   HALT_WORD instruction encoding that stops sequential fetch
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   stall        hold PC and IF/ID outputs this cycle
//   redirect     branch/jump taken; load redirect_pc
//   redirect_pc  redirect target word address
//   imem_addr    memory address (the pc register)
//   imem_wen     memory write enable, always 0
//   imem_wdata   memory write data, always 0
//   imem_rdata   combinational read data for imem_addr
//   if_instr     registered instruction
//   if_pc        registered PC of if_instr
//   if_valid     if_instr is a real instruction
//   halted       unit is in HALT
//   fetch_count  saturating count of issued instructions
module fetch_unit #(
  parameter int unsigned     AW        = 32,
  parameter int unsigned     DW        = 32,
  parameter int unsigned     DEPTH     = 1024,
  parameter logic [AW-1:0]   RESET_PC  = '0,
  parameter logic [DW-1:0]   HALT_WORD = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] imem_addr,
  output logic          imem_wen,
  output logic [DW-1:0] imem_wdata,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  output logic          if_valid,
  output logic          halted,
  output logic [15:0]   fetch_count
);

  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t        state,        state_nxt;
  logic [AW-1:0] pc,           pc_nxt;
  logic [DW-1:0] if_instr_q,   if_instr_nxt;
  logic [AW-1:0] if_pc_q,      if_pc_nxt;
  logic          if_valid_q,   if_valid_nxt;
  logic [15:0]   count_q,      count_nxt;

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] target_pc;
  logic          is_halt_word;

  assign pc_inc       = (pc == LAST_PC) ? '0 : pc + AW'(1);
  assign target_pc    = redirect_pc % DEPTH_W;
  assign is_halt_word = (imem_rdata == HALT_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      if_instr_q <= if_instr_nxt;
      if_pc_q    <= if_pc_nxt;
      if_valid_q <= if_valid_nxt;
      count_q    <= count_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    if_instr_nxt = if_instr_q;
    if_pc_nxt    = if_pc_q;
    if_valid_nxt = if_valid_q;
    count_nxt    = count_q;

    unique case (state)
      // One settling cycle after reset; inputs are ignored.
      BOOT: begin
        state_nxt    = RUN;
        if_valid_nxt = 1'b0;
      end

      RUN: begin
        if (redirect) begin
          // Redirect wins over stall and leaves one bubble.
          pc_nxt       = target_pc;
          if_valid_nxt = 1'b0;
          if_instr_nxt = '0;
        end else if (!stall) begin
          if_instr_nxt = imem_rdata;
          if_pc_nxt    = pc;
          if_valid_nxt = 1'b1;
          if (count_q != 16'hFFFF) begin
            count_nxt = count_q + 16'd1;
          end
          // The halt word is issued and counted, but the PC stays on it.
          if (is_halt_word) begin
            state_nxt = HALT;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end

      HALT: begin
        if (redirect) begin
          pc_nxt       = target_pc;
          state_nxt    = RUN;
          if_valid_nxt = 1'b0;
          if_instr_nxt = '0;
        end else if (!stall) begin
          if_valid_nxt = 1'b0;
          if_instr_nxt = '0;
        end
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  assign imem_addr   = pc;
  assign imem_wen    = 1'b0;
  assign imem_wdata  = '0;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_valid    = if_valid_q;
  assign halted      = (state == HALT);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int DEPTH = 1024;
  localparam logic [31:0] HALTW = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_wen;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [0:DEPTH-1];

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[9:0]];

  fetch_unit #(
    .AW(32), .DW(32), .DEPTH(1024), .RESET_PC(32'd0), .HALT_WORD(32'hFFFFFFFF)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_wen(imem_wen),
    .imem_wdata(imem_wdata), .imem_rdata(imem_rdata), .if_instr(if_instr),
    .if_pc(if_pc), .if_valid(if_valid), .halted(halted),
    .fetch_count(fetch_count)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: mode 0 = boot, 1 = run, 2 = halt.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_valid;
  int          m_cnt;

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [31:0] w;
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (redirect) begin
          m_pc = redirect_pc % DEPTH; m_valid = 0; m_instr = 0;
        end else if (!stall) begin
          w = mem[m_pc];
          m_instr = w; m_ipc = m_pc; m_valid = 1;
          if (m_cnt < 65535) m_cnt++;
          if (w == HALTW) m_mode = 2;
          else m_pc = (m_pc + 1) % DEPTH;
        end
      end
      default: begin
        if (redirect) begin
          m_pc = redirect_pc % DEPTH; m_mode = 1; m_valid = 0; m_instr = 0;
        end else if (!stall) begin
          m_valid = 0; m_instr = 0;
        end
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, m_valid});
    chk({tag, ".pc"}, if_pc, m_ipc);
    chk({tag, ".instr"}, if_instr, m_instr);
    chk({tag, ".halted"}, {31'd0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
    chk({tag, ".addr"}, imem_addr, m_pc);
    chk({tag, ".count"}, {16'd0, fetch_count}, m_cnt);
    chk({tag, ".wen"}, {31'd0, imem_wen}, 32'd0);
    chk({tag, ".wdata"}, imem_wdata, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 0;
  endtask

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        halted;
    logic [31:0] addr;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [22];

  initial begin
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h00000000; mem[1] = 32'h05031000; mem[2] = 32'h00000000;
    mem[3] = 32'h00430800; mem[4] = 32'h11111111; mem[5] = HALTW;
    mem[9] = 32'h03fa5000; mem[1023] = 32'h33333333;

    //          stall red rpc   valid pc    instr         halt addr  cnt
    tbl[0]  = '{0, 0, 0,        0, 0,    32'h0,        0, 0,    0};  // BOOT
    tbl[1]  = '{0, 0, 0,        1, 0,    32'h0,        0, 1,    1};
    tbl[2]  = '{0, 0, 0,        1, 1,    32'h05031000, 0, 2,    2};
    tbl[3]  = '{1, 0, 0,        1, 1,    32'h05031000, 0, 2,    2};
    tbl[4]  = '{1, 0, 0,        1, 1,    32'h05031000, 0, 2,    2};
    tbl[5]  = '{1, 0, 0,        1, 1,    32'h05031000, 0, 2,    2};
    tbl[6]  = '{0, 0, 0,        1, 2,    32'h0,        0, 3,    3};
    tbl[7]  = '{0, 0, 0,        1, 3,    32'h00430800, 0, 4,    4};
    tbl[8]  = '{1, 1, 9,        0, 3,    32'h0,        0, 9,    4};  // redirect over stall
    tbl[9]  = '{0, 0, 0,        1, 9,    32'h03fa5000, 0, 10,   5};
    tbl[10] = '{0, 1, 4,        0, 9,    32'h0,        0, 4,    5};
    tbl[11] = '{0, 0, 0,        1, 4,    32'h11111111, 0, 5,    6};
    tbl[12] = '{0, 0, 0,        1, 5,    32'hFFFFFFFF, 1, 5,    7};  // halt word issued
    tbl[13] = '{0, 0, 0,        0, 5,    32'h0,        1, 5,    7};
    tbl[14] = '{0, 0, 0,        0, 5,    32'h0,        1, 5,    7};
    tbl[15] = '{1, 0, 0,        0, 5,    32'h0,        1, 5,    7};
    tbl[16] = '{0, 1, 0,        0, 5,    32'h0,        0, 0,    7};  // resume
    tbl[17] = '{0, 0, 0,        1, 0,    32'h0,        0, 1,    8};
    tbl[18] = '{0, 1, 1023,     0, 0,    32'h0,        0, 1023, 8};
    tbl[19] = '{0, 0, 0,        1, 1023, 32'h33333333, 0, 0,    9};  // wrap
    tbl[20] = '{0, 0, 0,        1, 0,    32'h0,        0, 1,    10};
    tbl[21] = '{0, 1, 2047,     0, 0,    32'h0,        0, 1023, 10}; // target mod DEPTH

    do_reset();
    for (int i = 0; i < 22; i++) begin
      stall = tbl[i].stall; redirect = tbl[i].redirect; redirect_pc = tbl[i].rpc;
      step();
      chk($sformatf("tbl%0d.valid", i), {31'd0, if_valid}, {31'd0, tbl[i].valid});
      chk($sformatf("tbl%0d.pc", i), if_pc, tbl[i].pc);
      chk($sformatf("tbl%0d.instr", i), if_instr, tbl[i].instr);
      chk($sformatf("tbl%0d.halted", i), {31'd0, halted}, {31'd0, tbl[i].halted});
      chk($sformatf("tbl%0d.addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d.cnt", i), {16'd0, fetch_count}, {16'd0, tbl[i].cnt});
    end

    // Async reset pulse between edges while if_valid=1.
    stall = 0; redirect = 0;
    step();
    chk("arst.pre_valid", {31'd0, if_valid}, 32'd1);
    #2 rst = 1;
    #1;
    chk("arst.valid", {31'd0, if_valid}, 32'd0);
    chk("arst.pc", if_pc, 32'd0);
    chk("arst.instr", if_instr, 32'd0);
    chk("arst.addr", imem_addr, 32'd0);
    chk("arst.count", {16'd0, fetch_count}, 32'd0);
    chk("arst.halted", {31'd0, halted}, 32'd0);
    chk("arst.wen", {31'd0, imem_wen}, 32'd0);
    model_reset();
    #2 rst = 0;
    step();
    check_model("arst.boot");
    chk("arst.boot_valid", {31'd0, if_valid}, 32'd0);
    step();
    check_model("arst.refetch");
    chk("arst.refetch_pc", if_pc, 32'd0);
    chk("arst.refetch_valid", {31'd0, if_valid}, 32'd1);

    // Randomized traffic against the model, with halt words and NOPs in memory.
    for (int i = 0; i < DEPTH; i++) begin
      int r;
      r = $urandom_range(0, 15);
      mem[i] = (r == 0) ? HALTW : (r == 1) ? 32'h0 : ($urandom & 32'h7FFFFFFF);
    end
    do_reset();
    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      redirect_pc = $urandom_range(0, 2047);
      step();
      check_model($sformatf("rnd%0d", i));
    end

    // Long free run for counter saturation.
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h2000_0000 + i;
    do_reset();
    repeat (65540) step();
    check_model("sat");
    chk("sat.count", {16'd0, fetch_count}, 32'h0000FFFF);
    step();
    chk("sat.hold", {16'd0, fetch_count}, 32'h0000FFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
